// File: rtl/event_router_ml.sv
// event_router_ml: routes up to NUM_LANES candidate events per cycle into per-neuron pending score registers.
// Optional EVENT_ROUTER_STATS_EN adds saturating accepted/merged event counters.
module event_router_ml #(
  parameter int NUM_NEURONS = 16,
  parameter int NEURON_ID_W = 4,
  parameter int SCORE_W = 4,
  parameter int NUM_LANES = 2,
  parameter int MERGE_MODE = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           scan_start_en,
  input  logic [NUM_LANES-1:0]           cand_valid,
  output logic [NUM_LANES-1:0]           cand_ready,
  input  logic [NUM_LANES*NEURON_ID_W-1:0] cand_neuron,
  input  logic [NUM_LANES*SCORE_W-1:0]   cand_score,
  output logic [NUM_NEURONS-1:0]         lif_score_valid,
  output logic [NUM_NEURONS*SCORE_W-1:0] lif_score,
  input  logic [NUM_NEURONS-1:0]         lif_score_ready
`ifdef EVENT_ROUTER_STATS_EN
  ,
  output logic [31:0]                    stat_accepted,
  output logic [31:0]                    stat_merged
`endif
);
  localparam int SW = SCORE_W + $clog2(NUM_LANES + 1);
  localparam logic [SW-1:0] SAT = SW'((1 << SCORE_W) - 1);

  logic [NEURON_ID_W-1:0] id [NUM_LANES];
  logic [SCORE_W-1:0] sc [NUM_LANES];
  logic [NUM_LANES-1:0] in_range, blk, pv, pa, acc, merged;
  logic [NUM_NEURONS-1:0] busy, valid_d, hit;
  logic [NUM_NEURONS*SCORE_W-1:0] score_d;
  logic [SW-1:0] sum;

  assign busy = lif_score_valid & ~lif_score_ready;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      id[l] = cand_neuron[l*NEURON_ID_W +: NEURON_ID_W];
      sc[l] = cand_score[l*SCORE_W +: SCORE_W];
      in_range[l] = 32'(id[l]) < NUM_NEURONS;
    end
  end

  // blk: target still pending; pv/pa: a lower lane is valid/accepted on the same target
  always_comb begin
    blk = '0;
    pv = '0;
    pa = '0;
    acc = '0;
    merged = '0;
    cand_ready = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int n = 0; n < NUM_NEURONS; n++)
        if (id[l] == NEURON_ID_W'(n) && busy[n]) blk[l] = 1'b1;
      for (int k = 0; k < l; k++) begin
        if (cand_valid[k] && id[k] == id[l]) pv[l] = 1'b1;
        if (acc[k] && id[k] == id[l]) pa[l] = 1'b1;
      end
      cand_ready[l] = !scan_start_en && (MERGE_MODE != 0 || !in_range[l] || !(blk[l] || pv[l]));
      acc[l] = cand_valid[l] && cand_ready[l] && in_range[l];
      merged[l] = acc[l] && (blk[l] || pa[l]);
    end
  end

  always_comb begin
    valid_d = lif_score_valid & ~lif_score_ready;
    score_d = lif_score;
    hit = '0;
    sum = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      sum = (MERGE_MODE != 0 && busy[n]) ? SW'(lif_score[n*SCORE_W +: SCORE_W]) : '0;
      for (int l = 0; l < NUM_LANES; l++)
        if (acc[l] && id[l] == NEURON_ID_W'(n)) begin
          hit[n] = 1'b1;
          sum = (MERGE_MODE != 0 ? sum : '0) + SW'(sc[l]);
        end
      if (hit[n]) begin
        valid_d[n] = 1'b1;
        score_d[n*SCORE_W +: SCORE_W] = sum > SAT ? '1 : sum[SCORE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lif_score_valid <= '0;
      lif_score <= '0;
    end else if (scan_start_en) begin
      lif_score_valid <= '0;
      lif_score <= '0;
    end else begin
      lif_score_valid <= valid_d;
      lif_score <= score_d;
    end

`ifdef EVENT_ROUTER_STATS_EN
  logic [32:0] acc_sum, mrg_sum;

  always_comb begin
    acc_sum = {1'b0, stat_accepted};
    mrg_sum = {1'b0, stat_merged};
    for (int l = 0; l < NUM_LANES; l++) begin
      acc_sum = acc_sum + 33'(acc[l]);
      mrg_sum = mrg_sum + 33'(merged[l]);
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_accepted <= '0;
      stat_merged <= '0;
    end else if (scan_start_en) begin
      stat_accepted <= '0;
      stat_merged <= '0;
    end else begin
      stat_accepted <= acc_sum[32] ? '1 : acc_sum[31:0];
      stat_merged <= mrg_sum[32] ? '1 : mrg_sum[31:0];
    end
`endif
endmodule

// File: tb/tb_event_router_ml.sv
// tb_event_router_ml: scoreboard bench driving a merge-mode router (16 neurons) and a stall-mode router (12 neurons).
module tb_event_router_ml;
  typedef struct {
    logic [15:0] v;
    logic [63:0] s;
    logic [1:0]  r;
    logic [31:0] sa;
    logic [31:0] sm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][1:0] cv, nv, held;
  logic [1:0][7:0] cn, cs, nn, ns;
  logic [1:0] sse, nsse;
  logic [1:0][15:0] lr, nr;
  logic [1:0] crdy0, crdy1;
  logic [15:0] lv0;
  logic [11:0] lv1;
  logic [63:0] ls0;
  logic [47:0] ls1;
`ifdef EVENT_ROUTER_STATS_EN
  logic [31:0] sa0, sm0, sa1, sm1;
`endif

  int mv [2][16];
  int ms [2][16];
  int sa [2];
  int sm [2];
  exp_t q0[$];
  exp_t q1[$];
  int tests = 0;
  int fails = 0;

  event_router_ml dut_m (
    .clk(clk), .rst_n(rst_n), .scan_start_en(sse[0]),
    .cand_valid(cv[0]), .cand_ready(crdy0), .cand_neuron(cn[0]), .cand_score(cs[0]),
    .lif_score_valid(lv0), .lif_score(ls0), .lif_score_ready(lr[0])
`ifdef EVENT_ROUTER_STATS_EN
    , .stat_accepted(sa0), .stat_merged(sm0)
`endif
  );

  event_router_ml #(.NUM_NEURONS(12), .MERGE_MODE(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .scan_start_en(sse[1]),
    .cand_valid(cv[1]), .cand_ready(crdy1), .cand_neuron(cn[1]), .cand_score(cs[1]),
    .lif_score_valid(lv1), .lif_score(ls1), .lif_score_ready(lr[1][11:0])
`ifdef EVENT_ROUTER_STATS_EN
    , .stat_accepted(sa1), .stat_merged(sm1)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_valid_m", 64'(lv0), 64'd0);
    chk("rst_score_m", ls0, 64'd0);
    chk("rst_valid_s", 64'(lv1), 64'd0);
    chk("rst_score_s", 64'(ls1), 64'd0);
`ifdef EVENT_ROUTER_STATS_EN
    chk("rst_stats_m", {sa0, sm0}, 64'd0);
    chk("rst_stats_s", {sa1, sm1}, 64'd0);
`endif
  endtask

  task automatic clear_model(input int d);
    for (int n = 0; n < 16; n++) begin
      mv[d][n] = 0;
      ms[d][n] = 0;
    end
    sa[d] = 0;
    sm[d] = 0;
  endtask

  // Reference: d=0 merges colliding events, d=1 stalls lower-priority colliders.
  task automatic predict(input int d);
    exp_t e;
    int nnr;
    int id [2];
    int sc [2];
    int tot [16];
    bit hit [16];
    logic [1:0] rd;
    nnr = d == 0 ? 16 : 12;
    for (int l = 0; l < 2; l++) begin
      id[l] = int'(cn[d][l*4 +: 4]);
      sc[l] = int'(cs[d][l*4 +: 4]);
    end
    for (int l = 0; l < 2; l++) begin
      rd[l] = !sse[d];
      if (d == 1 && id[l] < nnr) begin
        if (mv[d][id[l]] != 0 && !lr[d][id[l]]) rd[l] = 1'b0;
        for (int k = 0; k < l; k++)
          if (cv[d][k] && id[k] == id[l]) rd[l] = 1'b0;
      end
    end
    for (int n = 0; n < 16; n++) begin
      e.v[n] = mv[d][n] != 0;
      e.s[n*4 +: 4] = 4'(ms[d][n]);
    end
    e.r = rd;
    e.sa = sa[d];
    e.sm = sm[d];
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    for (int l = 0; l < 2; l++) held[d][l] = cv[d][l] && !rd[l];
    if (sse[d]) begin
      clear_model(d);
      return;
    end
    for (int n = 0; n < 16; n++) begin
      hit[n] = 1'b0;
      tot[n] = (mv[d][n] != 0 && !lr[d][n]) ? ms[d][n] : 0;
    end
    for (int l = 0; l < 2; l++)
      if (cv[d][l] && rd[l] && id[l] < nnr) begin
        sa[d]++;
        if ((mv[d][id[l]] != 0 && !lr[d][id[l]]) || hit[id[l]]) sm[d]++;
        tot[id[l]] = d == 0 ? tot[id[l]] + sc[l] : sc[l];
        hit[id[l]] = 1'b1;
      end
    for (int n = 0; n < nnr; n++)
      if (hit[n]) begin
        mv[d][n] = 1;
        ms[d][n] = tot[n] > 15 ? 15 : tot[n];
      end else if (mv[d][n] != 0 && lr[d][n]) mv[d][n] = 0;
  endtask

  task automatic step();
    @(negedge clk);
    cv = nv;
    cn = nn;
    cs = ns;
    sse = nsse;
    lr = nr;
    #1;
    predict(0);
    predict(1);
  endtask

  task automatic drive(input logic [1:0] v, input int n0, input int s0, input int n1, input int s1,
                       input logic s, input logic [15:0] r);
    for (int d = 0; d < 2; d++) begin
      nv[d] = v;
      nn[d] = {4'(n1), 4'(n0)};
      ns[d] = {4'(s1), 4'(s0)};
      nsse[d] = s;
      nr[d] = r;
    end
    step();
  endtask

  // Stalled lanes keep their payload; free lanes get fresh random events with frequent same-id collisions.
  task automatic gen(input int pct);
    for (int d = 0; d < 2; d++) begin
      nsse[d] = $urandom_range(0, 31) == 0;
      nr[d] = 16'($urandom) & 16'($urandom);
      for (int l = 0; l < 2; l++)
        if (!held[d][l]) begin
          nv[d][l] = $urandom_range(0, 99) < pct;
          nn[d][l*4 +: 4] = 4'($urandom);
          ns[d][l*4 +: 4] = 4'($urandom);
        end
      if (!held[d][1] && $urandom_range(0, 1) == 1) nn[d][7:4] = nn[d][3:0];
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    cv = '0;
    sse = '0;
    lr = '0;
    #1 rst_n = 1'b0;
    #1 chk_zero();
    clear_model(0);
    clear_model(1);
    held = '0;
    nv = '0;
    #1 rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("valid_m", 64'(lv0), 64'(e.v));
        chk("score_m", ls0, e.s);
        chk("ready_m", 64'(crdy0), 64'(e.r));
`ifdef EVENT_ROUTER_STATS_EN
        chk("stat_acc_m", 64'(sa0), 64'(e.sa));
        chk("stat_mrg_m", 64'(sm0), 64'(e.sm));
`endif
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("valid_s", 64'(lv1), 64'(e.v));
        chk("score_s", 64'(ls1), e.s);
        chk("ready_s", 64'(crdy1), 64'(e.r));
`ifdef EVENT_ROUTER_STATS_EN
        chk("stat_acc_s", 64'(sa1), 64'(e.sa));
        chk("stat_mrg_s", 64'(sm1), 64'(e.sm));
`endif
      end
    end
  end

  initial begin
    nv = '0; nn = '0; ns = '0; nsse = '0; nr = '0;
    cv = '0; cn = '0; cs = '0; sse = '0; lr = '0; held = '0;
    clear_model(0);
    clear_model(1);
    #2 chk_zero();
    #1 rst_n = 1'b1;
    drive(2'b01, 3, 5, 0, 0, 1'b0, 16'h0000);
    repeat (10) drive(2'b00, 0, 0, 0, 0, 1'b0, 16'h0000);
    drive(2'b00, 0, 0, 0, 0, 1'b0, 16'h0008);
    drive(2'b00, 0, 0, 0, 0, 1'b0, 16'h0000);
    drive(2'b11, 7, 9, 7, 10, 1'b0, 16'h0000);
    drive(2'b11, 7, 2, 7, 10, 1'b0, 16'h0000);
    drive(2'b11, 7, 2, 7, 10, 1'b0, 16'h0080);
    drive(2'b10, 7, 2, 7, 10, 1'b0, 16'h0080);
    drive(2'b00, 0, 0, 0, 0, 1'b0, 16'h0080);
    drive(2'b01, 5, 3, 0, 0, 1'b0, 16'h0000);
    drive(2'b01, 5, 8, 0, 0, 1'b0, 16'h0020);
    drive(2'b00, 0, 0, 0, 0, 1'b0, 16'h0000);
    drive(2'b11, 1, 1, 4, 2, 1'b0, 16'h0000);
    drive(2'b01, 9, 3, 0, 0, 1'b0, 16'h0000);
    drive(2'b01, 2, 7, 0, 0, 1'b1, 16'h0000);
    drive(2'b01, 2, 7, 0, 0, 1'b0, 16'h0000);
    drive(2'b11, 13, 4, 14, 1, 1'b0, 16'h0000);
    drive(2'b00, 0, 0, 0, 0, 1'b0, 16'h0000);
    for (int i = 0; i < 3000; i++) begin
      gen(70);
      step();
      if (i % 700 == 699) async_reset();
    end
    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
